// File: rtl/imem_loader_pkg.sv
// Shared types and frame-format constants for the boot-time instruction loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         LEN_W        = 16;
  localparam int         CSUM_W       = 8;
  localparam int         WORD_W       = 32;

  // Frame length limit in words, one bit wider than LEN so any LEN compares cleanly.
  function automatic logic [LEN_W:0] max_words(input int rom_size);
    return (LEN_W+1)'(rom_size / 4);
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Packs accepted bytes little-endian into 32-bit words; byte 0 ends up in [7:0].
module loader_word_pack
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              last_byte
);

  logic [WORD_W-1:0] word_q;
  logic [1:0]        cnt_q;

  // Shifting right means the first byte lands in the low lane after four shifts.
  assign word_next = {byte_in, word_q[WORD_W-1:8]};
  assign last_byte = (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift) begin
      word_q <= word_next;
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes packed words to instruction memory and holds
// the core in reset until a full frame with a matching checksum has landed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ROM_SIZE = 512,
  parameter logic [7:0] SYNC     = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W:0] MAX_WORDS = max_words(ROM_SIZE);

  state_t              state_q, state_n;
  logic [7:0]          len_lo_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    word_cnt_q;
  logic [CSUM_W-1:0]   sum_q;
  logic [LEN_W-1:0]    len_in;
  logic [LEN_W:0]      words_after;
  logic                acc, restart, shift, write, last_byte;
  logic [WORD_W-1:0]   word_next;

  assign acc         = in_valid & in_ready;
  assign len_in      = {in_data, len_lo_q};
  assign words_after = (LEN_W+1)'(word_cnt_q) + 1'b1;
  assign write       = shift & last_byte;

  loader_word_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (restart),
    .shift     (shift),
    .byte_in   (in_data),
    .word_next (word_next),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    restart = 1'b0;
    shift   = 1'b0;
    if (acc) begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (in_data == SYNC) begin
            state_n = LEN_LO;
            restart = 1'b1;
          end
        end
        LEN_LO: state_n = LEN_HI;
        LEN_HI: begin
          if ({1'b0, len_in} > MAX_WORDS) state_n = ERROR;
          else if (len_in == '0)          state_n = CSUM;
          else                            state_n = DATA;
        end
        DATA: begin
          shift = 1'b1;
          // Leave DATA on the byte that completes word LEN-1.
          if (last_byte && (words_after == {1'b0, len_q})) state_n = CSUM;
        end
        CSUM:    state_n = (in_data == sum_q) ? DONE : ERROR;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      sum_q      <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      in_ready   <= 1'b1;
      mem_we     <= write;
      core_rst_n <= (state_n == DONE);
      done       <= (state_n == DONE);
      error      <= (state_n == ERROR);
      if (acc && state_q == LEN_LO) len_lo_q <= in_data;
      if (acc && state_q == LEN_HI) len_q    <= len_in;
      if (restart) begin
        word_cnt_q <= '0;
        sum_q      <= '0;
      end else if (shift) begin
        sum_q <= sum_q + in_data;
        if (write) word_cnt_q <= word_cnt_q + 1'b1;
      end
      if (write) begin
        mem_addr  <= WORD_W'(word_cnt_q) << 2;
        mem_wdata <= word_next;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are built at byte level,
// expected writes are queued at issue time and popped by an independent monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ROM_SIZE = 512;
  localparam int MAXW     = ROM_SIZE / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, core_rst_n, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.ROM_SIZE(ROM_SIZE), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  exp_done = 1'b0;
  bit  exp_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int rg(input int m);
    return (m == 0) ? 0 : int'($urandom_range(0, m));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_core_rst_n"}, core_rst_n, exp_done);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
  endtask

  // Reference model: words are payload bytes 4i..4i+3 little-endian at address 4i;
  // checksum is the byte sum of the payload; LEN above ROM_SIZE/4 rejects after LEN_HI.
  task automatic send_frame(input int len, input logic [7:0] payload[$], input bit bad,
                            input int max_gap, input int gap_idx);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [15:0] l16;
    sum = 8'h00;
    l16 = 16'(len);
    send_byte(8'hA5, rg(max_gap));
    exp_done = 1'b0;
    exp_err  = 1'b0;
    check_status("restart");
    send_byte(l16[7:0], rg(max_gap));
    send_byte(l16[15:8], rg(max_gap));
    if (len > MAXW) begin
      exp_err = 1'b1;
      check_status("oversize");
    end else begin
      for (int i = 0; i < 4 * len; i++) begin
        if (i % 4 == 3) begin
          w = {payload[i], payload[i-1], payload[i-2], payload[i-3]};
          exp_q.push_back('{addr: 32'((i / 4) * 4), data: w});
        end
        sum = sum + payload[i];
        send_byte(payload[i], (i == gap_idx) ? 3 : rg(max_gap));
      end
      send_byte(bad ? sum + 8'h01 : sum, rg(max_gap));
      exp_done = !bad;
      exp_err  = bad;
      check_status(bad ? "bad_csum" : "good_csum");
    end
    @(negedge clk); #1;
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom); while (b == 8'hA5);
      send_byte(b, rg(1));
    end
    check_status("after_junk");
  endtask

  logic [7:0] nom[$];
  logic [7:0] pl[$];

  initial begin
    int len, kind;
    logic [7:0] p;
    nom = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs();
    rst = 1'b1;

    // Nominal two-word frame, then the same with a corrupted checksum.
    send_frame(2, nom, 1'b0, 0, -1);
    send_frame(2, nom, 1'b1, 0, -1);
    // Oversize header: 129 words.
    send_frame(129, nom, 1'b0, 0, -1);
    // Junk while in ERROR, then nominal with a 3-cycle gap mid-word.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    check_status("noise");
    send_frame(2, nom, 1'b0, 0, 2);
    // Reload from DONE with a zero-length frame.
    send_frame(0, nom, 1'b0, 0, -1);

    // Reset after six payload bytes: only word 0 may be written.
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) exp_q.push_back('{addr: 32'h0, data: {nom[3], nom[2], nom[1], nom[0]}});
      send_byte(nom[i], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    rst = 1'b1;
    send_frame(2, nom, 1'b0, 0, -1);

    // Maximum-length frame.
    pl.delete();
    for (int i = 0; i < 4 * MAXW; i++) pl.push_back(8'($urandom));
    send_frame(MAXW, pl, 1'b0, 1, -1);

    // Randomized frames, junk and headers.
    for (int it = 0; it < 25; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        send_junk(int'($urandom_range(1, 3)));
      end else begin
        len = (kind == 1) ? int'($urandom_range(MAXW + 1, 65535)) : int'($urandom_range(0, 8));
        pl.delete();
        for (int i = 0; i < 4 * len && len <= MAXW; i++) begin
          p = 8'($urandom);
          pl.push_back(p);
        end
        send_frame(len, pl, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
